// File: rtl/cve2_counter_bank.sv
// ---------------------------------------------------------------------------
// cve2_counter_bank
//
// A bank of independent event counters with software-visible configuration.
// Each counter selects one event line, can be inhibited, and raises a sticky
// overflow flag when it wraps. The overflow flags feed one interrupt line,
// gated per counter by an enable bit.
//
// Ports
//   clk_i      : clock. All state updates on the rising edge.
//   rst_ni     : asynchronous, active-low reset.
//   event_i    : per-cycle event strobes, NumEvents wide.
//   wr_en_i    : write strobe.
//   wr_type_i  : write target. 0 = counter low word, 1 = counter high word,
//                2 = event config, 3 = inhibit mask.
//   wr_idx_i   : counter index for write types 0-2.
//   wr_data_i  : write data.
//   rd_idx_i   : counter index to read.
//   rd_val_o   : selected counter value, zero-extended to 64 bits.
//   rd_cfg_o   : selected counter config: [7:0] evsel, [30] ovie, [31] of.
//   inhibit_o  : current inhibit mask.
//   irq_o      : overflow interrupt.
// ---------------------------------------------------------------------------
module cve2_counter_bank #(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   event_i,
  input  logic                   wr_en_i,
  input  logic [1:0]             wr_type_i,
  input  logic [4:0]             wr_idx_i,
  input  logic [31:0]            wr_data_i,
  input  logic [4:0]             rd_idx_i,
  output logic [63:0]            rd_val_o,
  output logic [31:0]            rd_cfg_o,
  output logic [NumCounters-1:0] inhibit_o,
  output logic                   irq_o
);

  logic [CounterWidth-1:0] cnt_q   [NumCounters];
  logic [CounterWidth-1:0] cnt_d   [NumCounters];
  logic [7:0]              evsel_q [NumCounters];
  logic [7:0]              evsel_d [NumCounters];
  logic [NumCounters-1:0]  ovie_q, ovie_d;
  logic [NumCounters-1:0]  of_q, of_d;
  logic [NumCounters-1:0]  inhibit_q, inhibit_d;
  logic [NumCounters-1:0]  inc;
  logic [NumCounters-1:0]  wrap;
  logic [255:0]            event_ext;
  logic [63:0]             cnt_ext;
  logic                    sel;

  // Zero-padding the event vector to the full 8-bit select range makes any
  // evsel beyond NumEvents pick a constant zero, so that counter never counts.
  assign event_ext = 256'(event_i);

  always_comb begin
    inc  = '0;
    wrap = '0;
    for (int i = 0; i < NumCounters; i++) begin
      inc[i]  = event_ext[evsel_q[i]] & ~inhibit_q[i];
      wrap[i] = inc[i] & (&cnt_q[i]);
    end
  end

  // Next-state logic. A counter write replaces the value and drops that
  // cycle's increment, including its overflow. A config write still lets a
  // same-cycle wrap set the overflow flag. Out-of-range indices match no
  // counter and are therefore ignored.
  always_comb begin
    inhibit_d = inhibit_q;
    ovie_d    = ovie_q;
    of_d      = of_q;
    cnt_ext   = '0;
    sel       = 1'b0;
    for (int i = 0; i < NumCounters; i++) begin
      cnt_d[i]   = cnt_q[i];
      evsel_d[i] = evsel_q[i];
      sel        = wr_en_i && (wr_idx_i == 5'(i));
      cnt_ext    = 64'(cnt_q[i]);
      if (sel && (wr_type_i == 2'd0)) begin
        cnt_ext[31:0] = wr_data_i;
        cnt_d[i]      = cnt_ext[CounterWidth-1:0];
      end else if (sel && (wr_type_i == 2'd1) && (CounterWidth > 32)) begin
        cnt_ext[63:32] = wr_data_i;
        cnt_d[i]       = cnt_ext[CounterWidth-1:0];
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + CounterWidth'(1);
        if (wrap[i]) begin
          of_d[i] = 1'b1;
        end
      end
      if (sel && (wr_type_i == 2'd2)) begin
        evsel_d[i] = wr_data_i[7:0];
        ovie_d[i]  = wr_data_i[30];
        of_d[i]    = wr_data_i[31] | wrap[i];
      end
    end
    if (wr_en_i && (wr_type_i == 2'd3)) begin
      inhibit_d = wr_data_i[NumCounters-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
      ovie_q    <= '0;
      of_q      <= '0;
      inhibit_q <= '1;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= cnt_d[i];
        evsel_q[i] <= evsel_d[i];
      end
      ovie_q    <= ovie_d;
      of_q      <= of_d;
      inhibit_q <= inhibit_d;
    end
  end

  // Read mux over registered state; an index with no counter reads zero.
  always_comb begin
    rd_val_o = '0;
    rd_cfg_o = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (rd_idx_i == 5'(i)) begin
        rd_val_o = 64'(cnt_q[i]);
        rd_cfg_o = {of_q[i], ovie_q[i], 22'd0, evsel_q[i]};
      end
    end
  end

  assign inhibit_o = inhibit_q;
  assign irq_o     = |(of_q & ovie_q);

endmodule

// File: tb/tb_cve2_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_cve2_counter_bank
//
// Testbench for cve2_counter_bank with default parameters (4 counters,
// 48-bit, 16 events). Vectors are stored as {inputs, expected outputs}
// records; each one is driven on the falling edge, its expectation queued,
// and the queue is popped and compared just after the following rising edge.
// The asynchronous reset corner is exercised by hand at the end.
// ---------------------------------------------------------------------------
module tb_cve2_counter_bank;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] event_i;
  logic        wr_en_i;
  logic [1:0]  wr_type_i;
  logic [4:0]  wr_idx_i;
  logic [31:0] wr_data_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] rd_val_o;
  logic [31:0] rd_cfg_o;
  logic [3:0]  inhibit_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wr_en;
    logic [1:0]  wr_type;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [15:0] ev;
    logic [4:0]  rd_idx;
    logic [63:0] exp_val;
    logic [31:0] exp_cfg;
    logic        exp_irq;
    logic [3:0]  exp_inh;
  } vec_t;

  vec_t table_q[$];
  vec_t sb_q[$];

  cve2_counter_bank #(
    .NumCounters (4),
    .CounterWidth(48),
    .NumEvents   (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .event_i  (event_i),
    .wr_en_i  (wr_en_i),
    .wr_type_i(wr_type_i),
    .wr_idx_i (wr_idx_i),
    .wr_data_i(wr_data_i),
    .rd_idx_i (rd_idx_i),
    .rd_val_o (rd_val_o),
    .rd_cfg_o (rd_cfg_o),
    .inhibit_o(inhibit_o),
    .irq_o    (irq_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic void addVec(input string name, input logic wr_en,
                                 input logic [1:0] wr_type, input logic [4:0] wr_idx,
                                 input logic [31:0] wr_data, input logic [15:0] ev,
                                 input logic [4:0] rd_idx, input logic [63:0] exp_val,
                                 input logic [31:0] exp_cfg, input logic exp_irq,
                                 input logic [3:0] exp_inh);
    vec_t v;
    v.name    = name;
    v.wr_en   = wr_en;
    v.wr_type = wr_type;
    v.wr_idx  = wr_idx;
    v.wr_data = wr_data;
    v.ev      = ev;
    v.rd_idx  = rd_idx;
    v.exp_val = exp_val;
    v.exp_cfg = exp_cfg;
    v.exp_irq = exp_irq;
    v.exp_inh = exp_inh;
    table_q.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] exp_val,
                             input logic [31:0] exp_cfg, input logic exp_irq,
                             input logic [3:0] exp_inh);
    checks++;
    if (rd_val_o !== exp_val) begin
      errors++;
      $display("[TB] FAIL %s rd_val got %h want %h", name, rd_val_o, exp_val);
    end
    checks++;
    if (rd_cfg_o !== exp_cfg) begin
      errors++;
      $display("[TB] FAIL %s rd_cfg got %h want %h", name, rd_cfg_o, exp_cfg);
    end
    checks++;
    if (irq_o !== exp_irq) begin
      errors++;
      $display("[TB] FAIL %s irq got %b want %b", name, irq_o, exp_irq);
    end
    checks++;
    if (inhibit_o !== exp_inh) begin
      errors++;
      $display("[TB] FAIL %s inhibit got %b want %b", name, inhibit_o, exp_inh);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    vec_t e;
    @(negedge clk_i);
    wr_en_i   = v.wr_en;
    wr_type_i = v.wr_type;
    wr_idx_i  = v.wr_idx;
    wr_data_i = v.wr_data;
    event_i   = v.ev;
    rd_idx_i  = v.rd_idx;
    sb_q.push_back(v);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty got 0 want 1 entry", v.name);
    end else begin
      e = sb_q.pop_front();
      checkOutput(e.name, e.exp_val, e.exp_cfg, e.exp_irq, e.exp_inh);
    end
  endtask

  // Main sequence: reset check, table build, table run, async reset corner.
  initial begin
    rst_ni    = 1'b0;
    event_i   = '0;
    wr_en_i   = 1'b0;
    wr_type_i = '0;
    wr_idx_i  = '0;
    wr_data_i = '0;
    rd_idx_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset", 64'd0, 32'd0, 1'b0, 4'hF);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic counting on event 3 for counter 0.
    addVec("clr_inh", 1, 2'd3, 5'd0, 32'h0, 16'h0, 5'd0, 64'd0, 32'h0, 0, 4'h0);
    addVec("evsel0", 1, 2'd2, 5'd0, 32'h3, 16'h8, 5'd0, 64'd0, 32'h3, 0, 4'h0);
    for (int k = 1; k <= 10; k++)
      addVec($sformatf("count%0d", k), 0, 2'd0, 5'd0, 32'h0, 16'h8, 5'd0,
             64'(k), 32'h3, 0, 4'h0);
    addVec("other1", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd1, 64'd0, 32'h0, 0, 4'h0);
    addVec("other2", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd2, 64'd0, 32'h0, 0, 4'h0);
    addVec("other3", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd3, 64'd0, 32'h0, 0, 4'h0);
    addVec("rd_oob", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd7, 64'd0, 32'h0, 0, 4'h0);
    // Write beats a same-cycle increment.
    addVec("wr_prio", 1, 2'd0, 5'd0, 32'h100, 16'h8, 5'd0, 64'h100, 32'h3, 0, 4'h0);
    addVec("wr_hold", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd0, 64'h100, 32'h3, 0, 4'h0);
    addVec("wr_inc", 0, 2'd0, 5'd0, 32'h0, 16'h8, 5'd0, 64'h101, 32'h3, 0, 4'h0);
    // 48-bit wrap of counter 1 with interrupt enabled.
    addVec("c1_cfg", 1, 2'd2, 5'd1, 32'h4000_0005, 16'h0, 5'd1, 64'd0, 32'h4000_0005, 0, 4'h0);
    addVec("c1_hi", 1, 2'd1, 5'd1, 32'hFFFF, 16'h0, 5'd1, 64'hFFFF_0000_0000, 32'h4000_0005, 0, 4'h0);
    addVec("c1_lo", 1, 2'd0, 5'd1, 32'hFFFF_FFFE, 16'h0, 5'd1, 64'hFFFF_FFFF_FFFE, 32'h4000_0005, 0, 4'h0);
    addVec("c1_ev1", 0, 2'd0, 5'd0, 32'h0, 16'h20, 5'd1, 64'hFFFF_FFFF_FFFF, 32'h4000_0005, 0, 4'h0);
    addVec("c1_wrap", 0, 2'd0, 5'd0, 32'h0, 16'h20, 5'd1, 64'd0, 32'hC000_0005, 1, 4'h0);
    // Clearing the flag, then an out-of-range event select.
    addVec("of_clr", 1, 2'd2, 5'd1, 32'h4000_0005, 16'h0, 5'd1, 64'd0, 32'h4000_0005, 0, 4'h0);
    addVec("ev200", 1, 2'd2, 5'd1, 32'h4000_00C8, 16'hFFFF, 5'd1, 64'd1, 32'h4000_00C8, 0, 4'h0);
    addVec("frozen1", 0, 2'd0, 5'd0, 32'h0, 16'hFFFF, 5'd1, 64'd1, 32'h4000_00C8, 0, 4'h0);
    addVec("frozen2", 0, 2'd0, 5'd0, 32'h0, 16'hFFFF, 5'd1, 64'd1, 32'h4000_00C8, 0, 4'h0);
    // Wrap in the same cycle as a config write clearing the flag: set wins.
    addVec("sw_cfg", 1, 2'd2, 5'd1, 32'h4000_0001, 16'h0, 5'd1, 64'd1, 32'h4000_0001, 0, 4'h0);
    addVec("sw_hi", 1, 2'd1, 5'd1, 32'hFFFF, 16'h0, 5'd1, 64'hFFFF_0000_0001, 32'h4000_0001, 0, 4'h0);
    addVec("sw_lo", 1, 2'd0, 5'd1, 32'hFFFF_FFFF, 16'h0, 5'd1, 64'hFFFF_FFFF_FFFF, 32'h4000_0001, 0, 4'h0);
    addVec("sw_wins", 1, 2'd2, 5'd1, 32'h4000_0001, 16'h2, 5'd1, 64'd0, 32'hC000_0001, 1, 4'h0);
    addVec("sw_clr", 1, 2'd2, 5'd1, 32'h0000_0001, 16'h0, 5'd1, 64'd0, 32'h0000_0001, 0, 4'h0);
    // Inhibit mask with all events active.
    addVec("z0", 1, 2'd0, 5'd0, 32'h0, 16'h0, 5'd0, 64'd0, 32'h3, 0, 4'h0);
    addVec("z2", 1, 2'd0, 5'd2, 32'h0, 16'h0, 5'd2, 64'd0, 32'h0, 0, 4'h0);
    addVec("z3", 1, 2'd0, 5'd3, 32'h0, 16'h0, 5'd3, 64'd0, 32'h0, 0, 4'h0);
    addVec("inh2", 1, 2'd3, 5'd9, 32'h2, 16'h0, 5'd0, 64'd0, 32'h3, 0, 4'h2);
    for (int k = 1; k <= 5; k++)
      addVec($sformatf("inh_cnt%0d", k), 0, 2'd0, 5'd0, 32'h0, 16'hFFFF, 5'd0,
             64'(k), 32'h3, 0, 4'h2);
    addVec("inh_c1", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd1, 64'd0, 32'h1, 0, 4'h2);
    addVec("inh_c2", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd2, 64'd5, 32'h0, 0, 4'h2);
    addVec("inh_c3", 0, 2'd0, 5'd0, 32'h0, 16'h0, 5'd3, 64'd5, 32'h0, 0, 4'h2);
    addVec("wr_oob", 1, 2'd0, 5'd5, 32'h55, 16'h0, 5'd1, 64'd0, 32'h1, 0, 4'h2);
    // Raise the interrupt on counter 2 while it keeps counting.
    addVec("irq_set", 1, 2'd2, 5'd2, 32'hC000_0000, 16'hFFFF, 5'd2, 64'd6, 32'hC000_0000, 1, 4'h2);
    addVec("irq_run", 0, 2'd0, 5'd0, 32'h0, 16'hFFFF, 5'd2, 64'd7, 32'hC000_0000, 1, 4'h2);

    foreach (table_q[n]) applyStimulus(table_q[n]);

    // Reset asserted mid-cycle must clear outputs before the next edge.
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst", 64'd0, 32'd0, 1'b0, 4'hF);
    @(posedge clk_i);
    #1;
    checkOutput("rst_hold", 64'd0, 32'd0, 1'b0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cve2_counter_bank.md
CVE2_COUNTER_BANK -- requirements
Module: cve2_counter_bank

Interface
REQ-001 SHALL have parameter NumCounters, default 4, number of independent event counters (1..29).
REQ-002 SHALL have parameter CounterWidth, default 48, bits per counter (1..64).
REQ-003 SHALL have parameter NumEvents, default 16, number of event inputs (1..256).
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port event_i  input  NumEvents  per-cycle event strobes.
REQ-007 SHALL have port wr_en_i  input  1  write strobe.
REQ-008 SHALL have port wr_type_i  input  2  write target: 0 counter low, 1 counter high, 2 event config, 3 inhibit mask.
REQ-009 SHALL have port wr_idx_i  input  5  target counter index for types 0-2.
REQ-010 SHALL have port wr_data_i  input  32  write data.
REQ-011 SHALL have port rd_idx_i  input  5  counter index to read.
REQ-012 SHALL have port rd_val_o  output  64  selected counter value, zero-extended.
REQ-013 SHALL have port rd_cfg_o  output  32  selected counter config: [7:0] evsel, [30] ovie, [31] of.
REQ-014 SHALL have port inhibit_o  output  NumCounters  current inhibit mask.
REQ-015 SHALL have port irq_o  output  1  overflow interrupt.

Function
REQ-016 SHALL keep per counter i: cnt[i] (CounterWidth), evsel[i] (8b), ovie[i], of[i]; plus global inhibit[NumCounters-1:0].
REQ-017 SHALL define inc[i] = event_i[evsel[i]] & ~inhibit[i]; evsel[i] >= NumEvents gives inc[i]=0.
REQ-018 SHALL, when inc[i] and no write to cnt[i] this cycle, load cnt[i]+1 modulo 2^CounterWidth at next edge.
REQ-019 SHALL set of[i] at the edge where cnt[i] wraps from all-ones to zero by increment; of[i] is sticky.
REQ-020 SHALL, on type 0 write, load wr_data_i[CounterWidth-1:0] (min of widths) into cnt[i][31:0], keep upper bits.
REQ-021 SHALL, on type 1 write, load wr_data_i into cnt[i][CounterWidth-1:32]; ignore when CounterWidth <= 32.
REQ-022 SHALL give a counter write priority over a same-cycle increment of that counter; that increment is dropped and of[i] is unaffected.
REQ-023 SHALL, on type 2 write, load evsel[i]=wr_data_i[7:0], ovie[i]=wr_data_i[30], of[i]=wr_data_i[31]; a same-cycle wrap still sets of[i] (set wins).
REQ-024 SHALL, on type 3 write, load inhibit = wr_data_i[NumCounters-1:0]; wr_idx_i ignored.
REQ-025 SHALL ignore types 0-2 writes with wr_idx_i >= NumCounters.
REQ-026 SHALL apply every write to use from the following cycle; the write-cycle's inc[i] uses pre-write evsel/inhibit.
REQ-027 SHALL drive rd_val_o/rd_cfg_o combinationally from registered state; rd_idx_i >= NumCounters returns 0.
REQ-028 SHALL drive irq_o = OR over i of (of[i] & ovie[i]), from registered state only.
REQ-029 SHALL allow all counters to increment in the same cycle, independently.

Reset
REQ-030 SHALL, while rst_ni=0, force cnt=0, evsel=0, ovie=0, of=0, inhibit=all ones; hence rd_val_o=0, rd_cfg_o=0, irq_o=0, inhibit_o all ones.
REQ-031 SHALL abandon any in-flight write or increment when reset asserts mid-cycle; no partial update survives.

Verification
REQ-032 SHALL cover: inhibit=0, evsel[0]=3, event_i[3] high 10 cycles -> rd_val_o(0)=10; other counters 0.
REQ-033 SHALL cover: CounterWidth=48, write high 0xFFFF, low 0xFFFFFFFE, ovie[1]=1, two events -> cnt=0, of[1]=1, irq_o=1 after 2nd edge.
REQ-034 SHALL cover: type 0 write 0x100 and event on same cycle -> cnt=0x100, not 0x101.
REQ-035 SHALL cover: type 2 write with bit31=0 clears of[1] -> irq_o=0 next cycle; evsel=200 with NumEvents=16 -> counter frozen.
REQ-036 SHALL cover: inhibit=0b0010, all events high 5 cycles -> counters 0,2,3 = 5, counter 1 = 0.
REQ-037 SHALL cover: reset asserted mid-count -> all outputs at REQ-030 values immediately, before next clock edge.
